seven_segment_scanner: RTL

//  Parametrised N-digit multiplexed 7-segment driver for the stopwatch board; replaces the fixed 4-digit mux.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_encoder.sv | 17 +
 rtl/seven_segment_scanner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Glyph table and lookup helper shared by the 7-segment scanner and its encoder.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high abcdefg patterns (a at bit 6), entry 15 first so [n] indexes nibble n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77,
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] g;
        if (nibble > 4'd9 && !hex_mode) begin
            g = SEG_BLANK;
        end else begin
            g = GLYPH_TABLE[nibble];
        end
        return g;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Maps one nibble plus DP and blank request to an active-high {dp, abcdefg} pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    input  logic       hex_mode,
    output logic [7:0] pattern
);

    // The DP is independent of blanking so a suppressed digit can still show its point.
    assign pattern = {dp, blank ? SEG_BLANK : glyph(nibble, hex_mode)};

endmodule

// File: rtl/seven_segment_scanner.sv
// N-digit multiplexed 7-segment driver with per-frame snapshot, dead time and PWM dimming.
// Latency: segments/anodes/frame_tick are registered, one cycle behind the scan counters.
// Backpressure: none; the display scans continuously and ignores inputs between frame ends.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*N_DIGITS-1:0]   numbers,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [7:0]              segments,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_tick
);

    localparam int SW = $clog2(CLK_DIV);
    localparam int DW = $clog2(N_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_DEAD  = SW'(DEAD_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACT_LOW}};

    logic [SW-1:0]         slot_cnt;
    logic [DW-1:0]         digit_idx;
    logic [3:0]            pwm_cnt;

    logic [4*N_DIGITS-1:0] snap_numbers;
    logic [N_DIGITS-1:0]   snap_dp;
    logic                  snap_hex;
    logic                  snap_lz;

    logic                  slot_wrap;
    logic                  frame_end;
    logic [N_DIGITS-1:0]   lz_blank;
    logic                  zero_above;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            pattern;
    logic                  an_on;
    logic [N_DIGITS-1:0]   an_onehot;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_idx == DIGIT_LAST);

    // Leading-zero mask: walk from the leftmost digit down while every nibble so far is zero.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (snap_numbers[4*i +: 4] == 4'd0);
            lz_blank[i] = snap_lz && zero_above && (i != 0);
        end
    end

    always_comb begin
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == DW'(i)) begin
                cur_nibble = snap_numbers[4*i +: 4];
                cur_dp     = snap_dp[i];
                cur_blank  = lz_blank[i];
            end
        end
    end

    seg7_encoder u_encoder (
        .nibble   (cur_nibble),
        .dp       (cur_dp),
        .blank    (cur_blank),
        .hex_mode (snap_hex),
        .pattern  (pattern)
    );

    assign an_on     = (slot_cnt >= SLOT_DEAD) && (brightness == 4'hF || pwm_cnt < brightness);
    assign an_onehot = N_DIGITS'(1) << digit_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            pwm_cnt    <= 4'd0;
            frame_tick <= 1'b0;
            segments   <= SEG_OFF;
            anodes     <= AN_OFF;
        end else begin
            if (slot_wrap) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            pwm_cnt    <= pwm_cnt + 4'd1;
            frame_tick <= frame_end;
            segments   <= pattern ^ SEG_OFF;
            anodes     <= an_on ? (an_onehot ^ AN_OFF) : AN_OFF;
        end
    end

    // Snapshot tracks the inputs throughout reset so the first frame shows current data.
    always_ff @(posedge CLK) begin
        if (RST || frame_end) begin
            snap_numbers <= numbers;
            snap_dp      <= dp;
            snap_hex     <= hex_mode;
            snap_lz      <= blank_lz;
        end
    end

endmodule
